// File: rtl/conv_read_responder.sv
// Read-side memory responder for the convolution controller: synchronous RAM with a preload
// write port and a fixed-latency read pipeline. Define WRITE_FORWARD_EN for write-first collisions.
module conv_read_responder #(
    parameter int DataWidth    = 32,
    parameter int MaxAddrWidth = 32,
    parameter int Depth        = 1024,
    parameter int ReadLatency  = 1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    read_en_in,
    input  logic [MaxAddrWidth-1:0] read_addr_in,
    input  logic                    wr_en_in,
    input  logic [MaxAddrWidth-1:0] wr_addr_in,
    input  logic [DataWidth-1:0]    wr_data_in,
    output logic [DataWidth-1:0]    read_rdata_out,
    output logic                    read_valid_out,
    output logic                    addr_err_out,
    output logic [31:0]             read_count_out
);

    localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [MaxAddrWidth-1:0] DepthLimit = MaxAddrWidth'(Depth);

    logic [DataWidth-1:0] r_mem [0:Depth-1];
    logic [DataWidth-1:0] r_ram_q;
    logic                 r_s1_valid;
    logic                 r_s1_zero;
    logic                 r_addr_err;
    logic [31:0]          r_read_count;

    logic                 w_rd_in_range;
    logic                 w_wr_in_range;
    logic [IdxWidth-1:0]  w_rd_idx;
    logic [IdxWidth-1:0]  w_wr_idx;

    logic [DataWidth-1:0]   w_stage_data [0:ReadLatency-1];
    logic [ReadLatency-1:0] w_stage_valid;

    // Range check uses the full address so wide addresses are flagged, never aliased.
    assign w_rd_in_range = (read_addr_in < DepthLimit);
    assign w_wr_in_range = (wr_addr_in < DepthLimit);
    assign w_rd_idx      = read_addr_in[IdxWidth-1:0];
    assign w_wr_idx      = wr_addr_in[IdxWidth-1:0];

`ifdef WRITE_FORWARD_EN
    logic w_fwd;
    assign w_fwd = wr_en_in && w_wr_in_range && (wr_addr_in == read_addr_in);

    always_ff @(posedge Clk) begin
        if (wr_en_in && w_wr_in_range) begin
            r_mem[w_wr_idx] <= wr_data_in;
        end
        if (read_en_in) begin
            r_ram_q <= w_fwd ? wr_data_in : r_mem[w_rd_idx];
        end
    end
`else
    always_ff @(posedge Clk) begin
        if (wr_en_in && w_wr_in_range) begin
            r_mem[w_wr_idx] <= wr_data_in;
        end
        if (read_en_in) begin
            r_ram_q <= r_mem[w_rd_idx];
        end
    end
`endif

    // r_s1_zero masks the unreset RAM register after reset and for out-of-range reads.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_zero    <= 1'b1;
            r_addr_err   <= 1'b0;
            r_read_count <= 32'd0;
        end else begin
            r_s1_valid <= read_en_in;
            if (read_en_in) begin
                r_s1_zero <= !w_rd_in_range;
            end
            if ((read_en_in && !w_rd_in_range) || (wr_en_in && !w_wr_in_range)) begin
                r_addr_err <= 1'b1;
            end
            if (read_en_in && (r_read_count != 32'hFFFF_FFFF)) begin
                r_read_count <= r_read_count + 32'd1;
            end
        end
    end

    assign w_stage_data[0]  = r_s1_zero ? '0 : r_ram_q;
    assign w_stage_valid[0] = r_s1_valid;

    genvar gi;
    generate
        for (gi = 1; gi < ReadLatency; gi++) begin : g_stage
            logic [DataWidth-1:0] r_data;
            logic                 r_valid;

            // Data only advances with a valid beat so idle cycles hold the last response.
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_stage_valid[gi-1];
                    if (w_stage_valid[gi-1]) begin
                        r_data <= w_stage_data[gi-1];
                    end
                end
            end

            assign w_stage_data[gi]  = r_data;
            assign w_stage_valid[gi] = r_valid;
        end
    endgenerate

    assign read_rdata_out = w_stage_data[ReadLatency-1];
    assign read_valid_out = w_stage_valid[ReadLatency-1];
    assign addr_err_out   = r_addr_err;
    assign read_count_out = r_read_count;

endmodule

// File: tb/tb_conv_read_responder.sv
// Scoreboard bench for conv_read_responder: three instances (latency 1, 3, 4) share one
// directed stimulus stream; each has its own queue of expected responses and due cycles.
module tb_conv_read_responder;

    localparam int NDUT = 3;
    localparam int LAT [NDUT] = '{1, 3, 4};

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        read_en_in = 1'b0;
    logic [31:0] read_addr_in = 32'd0;
    logic        wr_en_in = 1'b0;
    logic [31:0] wr_addr_in = 32'd0;
    logic [31:0] wr_data_in = 32'd0;

    logic [31:0] rdata_w [NDUT];
    logic        vld_w   [NDUT];
    logic        err_w   [NDUT];
    logic [31:0] cnt_w   [NDUT];

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q [NDUT][$];
    logic [31:0] mem_m [0:1023];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_reads = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            conv_read_responder #(
                .DataWidth(32), .MaxAddrWidth(32), .Depth(1024), .ReadLatency(LAT[gi])
            ) u_dut (
                .Clk(Clk),
                .Rst(Rst),
                .read_en_in(read_en_in),
                .read_addr_in(read_addr_in),
                .wr_en_in(wr_en_in),
                .wr_addr_in(wr_addr_in),
                .wr_data_in(wr_data_in),
                .read_rdata_out(rdata_w[gi]),
                .read_valid_out(vld_w[gi]),
                .addr_err_out(err_w[gi]),
                .read_count_out(cnt_w[gi])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Response monitor: pops on every valid, flags spurious or overdue responses.
    always @(negedge Clk) begin
        for (int k = 0; k < NDUT; k++) begin
            exp_t e;
            if (vld_w[k]) begin
                if (q[k].size() == 0) begin
                    chk($sformatf("spurious_valid_L%0d", LAT[k]), {31'd0, vld_w[k]}, 32'd0);
                end else begin
                    e = q[k].pop_front();
                    chk($sformatf("rdata_L%0d", LAT[k]), rdata_w[k], e.data);
                    chk($sformatf("latency_L%0d", LAT[k]), 32'(cyc), 32'(e.due));
                    $display("resp L%0d cyc %0d data %0h", LAT[k], cyc, rdata_w[k]);
                end
            end else if (q[k].size() > 0 && cyc >= q[k][0].due) begin
                e = q[k].pop_front();
                chk($sformatf("missing_valid_L%0d", LAT[k]), {31'd0, vld_w[k]}, 32'd1);
            end
        end
    end

    // One clock cycle of stimulus; the request is accepted at edge cyc+1.
    task automatic step(input logic ren, input logic [31:0] ra,
                        input logic wen, input logic [31:0] wa, input logic [31:0] wd);
        logic [31:0] e;
        exp_t        ent;
        @(posedge Clk);
        #1;
        read_en_in   = ren;
        read_addr_in = ra;
        wr_en_in     = wen;
        wr_addr_in   = wa;
        wr_data_in   = wd;
        if (ren) begin
            e = (ra < 32'd1024) ? mem_m[ra[9:0]] : 32'd0;
`ifdef WRITE_FORWARD_EN
            if (wen && (wa == ra) && (ra < 32'd1024)) e = wd;
`endif
            for (int k = 0; k < NDUT; k++) begin
                ent.data = e;
                ent.due  = cyc + 1 + LAT[k] - 1;
                q[k].push_back(ent);
            end
            n_reads++;
        end
        if (wen && (wa < 32'd1024)) mem_m[wa[9:0]] = wd;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic check_counts(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("%s_count_L%0d", tag, LAT[k]), cnt_w[k], 32'(n_reads));
            chk($sformatf("%s_drained_L%0d", tag, LAT[k]), 32'(q[k].size()), 32'd0);
        end
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("reset_rdata_L%0d", LAT[k]), rdata_w[k], 32'd0);
            chk($sformatf("reset_valid_L%0d", LAT[k]), {31'd0, vld_w[k]}, 32'd0);
            chk($sformatf("reset_err_L%0d", LAT[k]), {31'd0, err_w[k]}, 32'd0);
            chk($sformatf("reset_count_L%0d", LAT[k]), cnt_w[k], 32'd0);
        end
        Rst = 1'b0;

        // Preload and back-to-back readback.
        for (int i = 0; i < 9; i++) step(1'b0, 32'd0, 1'b1, 32'(i), 32'(10 + i));
        for (int i = 0; i < 9; i++) step(1'b1, 32'(i), 1'b0, 32'd0, 32'd0);
        idle(6);
        check_counts("b2b");

        // Single read then idle: data must hold with valid low.
        step(1'b1, 32'd5, 1'b0, 32'd0, 32'd0);
        idle(5);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("hold_rdata_L%0d", LAT[k]), rdata_w[k], 32'd15);
            chk($sformatf("hold_valid_L%0d", LAT[k]), {31'd0, vld_w[k]}, 32'd0);
            chk($sformatf("pre_err_L%0d", LAT[k]), {31'd0, err_w[k]}, 32'd0);
        end

        // Out-of-range read (would alias to addr 2), then a legal read of addr 2.
        step(1'b1, 32'd1026, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("err_not_early_L%0d", LAT[k]), {31'd0, err_w[k]}, 32'd0);
        step(1'b1, 32'd2, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("err_set_L%0d", LAT[k]), {31'd0, err_w[k]}, 32'd1);
        idle(6);
        check_counts("oor");

        // Same-cycle read/write collision on addr 7, then a follow-up read.
        step(1'b1, 32'd7, 1'b1, 32'd7, 32'd99);
        step(1'b1, 32'd7, 1'b0, 32'd0, 32'd0);
        idle(6);
        check_counts("coll");
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("err_sticky_L%0d", LAT[k]), {31'd0, err_w[k]}, 32'd1);

        // Three reads, one idle cycle, then asynchronous reset mid-cycle.
        step(1'b1, 32'd3, 1'b0, 32'd0, 32'd0);
        step(1'b1, 32'd4, 1'b0, 32'd0, 32'd0);
        step(1'b1, 32'd5, 1'b0, 32'd0, 32'd0);
        idle(1);
        @(posedge Clk);
        #1;
        read_en_in = 1'b0;
        Rst = 1'b1;
        for (int k = 0; k < NDUT; k++) q[k].delete();
        n_reads = 0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("async_rdata_L%0d", LAT[k]), rdata_w[k], 32'd0);
            chk($sformatf("async_valid_L%0d", LAT[k]), {31'd0, vld_w[k]}, 32'd0);
            chk($sformatf("async_err_L%0d", LAT[k]), {31'd0, err_w[k]}, 32'd0);
            chk($sformatf("async_count_L%0d", LAT[k]), cnt_w[k], 32'd0);
        end
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        idle(6);
        for (int i = 0; i < 3; i++) step(1'b1, 32'(i), 1'b0, 32'd0, 32'd0);
        idle(6);
        check_counts("post_rst");

        // Out-of-range write is discarded but flagged.
        step(1'b0, 32'd0, 1'b1, 32'd5000, 32'hDEAD);
        idle(1);
        for (int k = 0; k < NDUT; k++)
            chk($sformatf("wr_err_L%0d", LAT[k]), {31'd0, err_w[k]}, 32'd1);

        // Twenty reads with random idle gaps.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 32'($urandom_range(0, 8)), 1'b0, 32'd0, 32'd0);
            idle($urandom_range(0, 3));
        end
        idle(6);
        check_counts("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
